mips_mdu: RTL and testbench

MIPS_MDU -- requirements
Module: mips_mdu

---
 rtl/mips_mdu_pkg.sv | 21 ++
 rtl/mips_mdu_core.sv | 42 ++++
 rtl/mips_mdu.sv | 155 +++++++++++++++
 tb/tb_mips_mdu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mdu_pkg.sv
// Shared op-code and controller state encodings for the MIPS multiply/divide unit.
// The divider is present only when MIPS_MDU_DIV_EN is defined.
package mips_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_SIGN = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mips_mdu_core.sv
// One radix-2 iteration: shift-add multiply step, or restoring shift-subtract
// divide step when MIPS_MDU_DIV_EN is defined.
module mips_mdu_core #(
    parameter int WIDTH = 32
) (
`ifdef MIPS_MDU_DIV_EN
    input  logic             i_is_div,
`endif
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_opnd} : '0);

`ifdef MIPS_MDU_DIV_EN
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
    assign w_rem_sh = {i_acc_hi, i_acc_lo[WIDTH-1]};
    assign w_ge     = w_rem_sh >= {1'b0, i_opnd};
    assign w_sub    = w_rem_sh[WIDTH-1:0] - i_opnd;
`endif

    always_comb begin
        o_acc_hi = w_sum[WIDTH:1];
        o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
`ifdef MIPS_MDU_DIV_EN
        if (i_is_div) begin
            o_acc_hi = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
            o_acc_lo = {i_acc_lo[WIDTH-2:0], w_ge};
        end
`endif
    end

endmodule

// File: rtl/mips_mdu.sv
// MIPS HI/LO multiply/divide unit: controller, sign fix-up and HI/LO registers.
// Define MIPS_MDU_DIV_EN to include DIV/DIVU; otherwise they complete as no-ops.
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
    logic [WIDTH-1:0]   w_core_hi, w_core_lo, w_rs_mag, w_rt_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               r_neg_res, r_mt_done;
    logic               w_signed, w_is_mul, w_iter;
`ifdef MIPS_MDU_DIV_EN
    logic               r_is_div, r_neg_rem, r_div_zero;
    logic               w_is_div;

    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_iter   = w_is_mul || w_is_div;
`else
    assign w_iter   = w_is_mul;
`endif

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_rs_mag = (w_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_mag = (w_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign w_prod   = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};

    mips_mdu_core #(.WIDTH(WIDTH)) u_core (
`ifdef MIPS_MDU_DIV_EN
        .i_is_div (r_is_div),
`endif
        .i_acc_hi (r_acc_hi),
        .i_acc_lo (r_acc_lo),
        .i_opnd   (r_opnd),
        .o_acc_hi (w_core_hi),
        .o_acc_lo (w_core_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && w_iter) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_SIGN;
            S_SIGN:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_res  <= 1'b0;
            r_mt_done  <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_mt_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            r_acc_hi  <= '0;
                            r_acc_lo  <= w_rt_mag;
                            r_opnd    <= w_rs_mag;
                            r_neg_res <= w_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            r_cnt     <= '0;
`ifdef MIPS_MDU_DIV_EN
                            r_is_div  <= 1'b0;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MIPS_MDU_DIV_EN
                            r_acc_hi   <= '0;
                            r_acc_lo   <= w_rs_mag;
                            r_opnd     <= w_rt_mag;
                            r_neg_res  <= w_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            r_neg_rem  <= w_signed && rs_val[WIDTH-1];
                            r_div_zero <= (rt_val == '0);
                            r_cnt      <= '0;
                            r_is_div   <= 1'b1;
`else
                            r_mt_done  <= 1'b1;
`endif
                        end
                        OP_MTHI: begin
                            r_hi      <= rs_val;
                            r_mt_done <= 1'b1;
                        end
                        OP_MTLO: begin
                            r_lo      <= rs_val;
                            r_mt_done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_CALC: begin
                    r_acc_hi <= w_core_hi;
                    r_acc_lo <= w_core_lo;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_SIGN: begin
`ifdef MIPS_MDU_DIV_EN
                    if (r_is_div) begin
                        // A zero divisor leaves the dividend magnitude as remainder; its sign fix restores rs.
                        r_lo <= r_div_zero ? '1 : (r_neg_res ? -r_acc_lo : r_acc_lo);
                        r_hi <= r_neg_rem ? -r_acc_hi : r_acc_hi;
                    end else
`endif
                    begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE) || r_mt_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_mdu.sv
// Self-checking bench for mips_mdu: directed corner cases plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_mips_mdu;

    localparam int W = 32;
`ifdef MIPS_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mips_mdu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output bit iter, output bit dn);
        logic [63:0] p;
        longint      q, r;
        iter = 1'b0;
        dn   = 1'b1;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = p;
                iter = 1'b1;
            end
            3'd1: begin
                p = {32'h0, a} * {32'h0, b};
                {m_hi, m_lo} = p;
                iter = 1'b1;
            end
            3'd2, 3'd3: begin
                if (DIV_EN) begin
                    iter = 1'b1;
                    if (b == 32'h0) begin
                        m_hi = a;
                        m_lo = '1;
                    end else if (o == 3'd2) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                    end else begin
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: dn = 1'b0;
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit           iter, dn;
        logic [W-1:0] old_hi, old_lo;
        int           n;
        old_hi = m_hi;
        old_lo = m_lo;
        model(o, a, b, iter, dn);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        if (!iter) begin
            check("sc_done", 64'(done), 64'(dn));
            check("sc_busy", 64'(busy), 64'h0);
            check("sc_hi", 64'(hi), 64'(m_hi));
            check("sc_lo", 64'(lo), 64'(m_lo));
        end else begin
            check("it_busy", 64'(busy), 64'h1);
            rs_val = $urandom;
            rt_val = $urandom;
            while (!done && n < W + 8) begin
                if (n == 5) begin
                    start  = 1'b1;
                    op     = 3'($urandom_range(0, 7));
                    rs_val = $urandom;
                end
                if (n == 6) start = 1'b0;
                if (n == W + 1) begin
                    check("hold_hi", 64'(hi), 64'(old_hi));
                    check("hold_lo", 64'(lo), 64'(old_lo));
                end
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            check("latency", 64'(n), 64'(W + 2));
            check("done_busy", 64'(busy), 64'h1);
            check("res_hi", 64'(hi), 64'(m_hi));
            check("res_lo", 64'(lo), 64'(m_lo));
            @(negedge clk);
            check("post_done", 64'(done), 64'h0);
            check("post_busy", 64'(busy), 64'h0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned n_done;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        rst = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo), 64'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        if (DIV_EN) begin
            check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
            check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        end
        run_op(3'd3, 32'd100, 32'd0);
        if (DIV_EN) begin
            check("divu_zero_hi", 64'(hi), 64'd100);
            check("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
        end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        if (DIV_EN) begin
            check("div_ovf_lo", 64'(lo), 64'h8000_0000);
            check("div_ovf_hi", 64'(hi), 64'h0);
        end
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0);

        run_op(3'd4, 32'h1234, 32'h0);
        run_op(3'd5, 32'h5678, 32'h0);
        check("mt_hi", 64'(hi), 64'h1234);
        check("mt_lo", 64'(lo), 64'h5678);
        run_op(3'd6, $urandom, $urandom);
        run_op(3'd7, $urandom, $urandom);

        for (int i = 0; i < 120; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick());

        run_op(3'd1, 32'd5, 32'd5);
        check("multu5_hi", 64'(hi), 64'h0);
        check("multu5_lo", 64'(lo), 64'd25);
        op = 3'd2; rs_val = $urandom; rt_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_hi", 64'(hi), 64'h0);
        check("abort_lo", 64'(lo), 64'h0);
        n_done = 0;
        repeat (W + 8) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(n_done), 64'h0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
